// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing.
// Intended for reuse by both the transmitter and a future receiver.
package uart_pkg;

  localparam int SYS_CLK_HZ           = 12000000;
  localparam int DEFAULT_BAUD         = 9600;
  localparam int DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / DEFAULT_BAUD;
  localparam int BIT_CNT_W            = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with wrapping pointers and an explicit occupancy count,
// so that full and empty never alias.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (PTR_W + 1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr];

  // NOTE: the storage array is deliberately not reset; the count alone
  // defines which entries are valid, so clearing the data buys nothing.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter (8N1) fed by a small byte FIFO; frames are sent
// back-to-back while the FIFO holds data.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_valid,
  input  logic [7:0] data_byte,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t          r_state;
  logic [BIT_CNT_W-1:0] r_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_tx;
  logic                 r_ready_en;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_bit_done;
  logic [7:0] w_fifo_dout;

  assign w_bit_done = (r_cnt == CNT_LAST);
  assign w_push     = data_valid & ready;
  // The head byte leaves the FIFO when a frame starts from idle or chains from a stop bit.
  assign w_pop      = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_bit_done));
  assign ready      = r_ready_en & ~w_full;
  assign busy       = (r_state != IDLE) | ~w_empty;
  assign tx         = r_tx;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (data_byte),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // NOTE: all state here updates with non-blocking assignments so every
  // branch reads the pre-edge values of r_shift, r_bit_idx and r_cnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          r_tx      <= 1'b1;
          if (w_pop) begin
            r_shift <= w_fifo_dout;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_done) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_cnt <= r_cnt + BIT_CNT_W'(1);
          end
        end
        DATA: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[r_bit_idx + 3'd1];
            end
          end else begin
            r_cnt <= r_cnt + BIT_CNT_W'(1);
          end
        end
        STOP: begin
          if (w_bit_done) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            if (w_pop) begin
              r_shift <= w_fifo_dout;
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + BIT_CNT_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
